// File: rtl/inst_fetch_mod.sv
// ============================================================================
// Module   : inst_fetch_mod
// Purpose  : Fetches opcode and immediate bytes from the memory bus and builds
//            the 9-bit opcode index (CB prefix folded into bit 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch_mod #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rd_data,
  output logic        opcode_valid,
  output logic [8:0]  opcode_index,
  input  logic        opcode_take,
  input  logic        imm_req,
  output logic        imm_valid,
  output logic [7:0]  imm_data,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic [15:0] pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_FETCH_CB = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_IMM      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [8:0]  op_idx_q, op_idx_d;
  logic        op_valid_q, op_valid_d;
  logic [7:0]  imm_data_q, imm_data_d;
  logic        imm_valid_q, imm_valid_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_idx_d    = op_idx_q;
    op_valid_d  = op_valid_q;
    imm_data_d  = imm_data_q;
    imm_valid_d = 1'b0;
    // A redirect discards any read completing on the same edge.
    if (pc_load) begin
      pc_d       = pc_load_value;
      op_valid_d = 1'b0;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            pc_d = pc_inc;
            if (mem_rd_data == CB_PREFIX) begin
              state_d = S_FETCH_CB;
            end else begin
              op_idx_d   = {1'b0, mem_rd_data};
              op_valid_d = 1'b1;
              state_d    = S_HOLD;
            end
          end
        end
        S_FETCH_CB: begin
          if (mem_ready) begin
            pc_d       = pc_inc;
            op_idx_d   = {1'b1, mem_rd_data};
            op_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (opcode_take) begin
            op_valid_d = 1'b0;
            state_d    = S_FETCH;
          end else if (imm_req) begin
            state_d = S_IMM;
          end
        end
        S_IMM: begin
          if (mem_ready) begin
            pc_d        = pc_inc;
            imm_data_d  = mem_rd_data;
            imm_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      op_idx_q    <= 9'd0;
      op_valid_q  <= 1'b0;
      imm_data_q  <= 8'd0;
      imm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_idx_q    <= op_idx_d;
      op_valid_q  <= op_valid_d;
      imm_data_q  <= imm_data_d;
      imm_valid_q <= imm_valid_d;
    end
  end

  // Bus request decodes from state so reset drops it without waiting for an edge.
  assign mem_rd = (state_q == S_FETCH) || (state_q == S_FETCH_CB) || (state_q == S_IMM);
  assign mem_addr     = mem_rd ? pc_q : 16'h0000;
  assign opcode_valid = op_valid_q;
  assign opcode_index = op_idx_q;
  assign imm_valid    = imm_valid_q;
  assign imm_data     = imm_data_q;
  assign pc           = pc_q;

endmodule

`default_nettype wire
